// File: rtl/rand_arb_pkg.sv
// Shared types and LFSR constants for the random-source arbiter.
package rand_arb_pkg;

  typedef enum logic [1:0] {WARMUP, IDLE, GRANT} arb_state_t;

  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = '1;

endpackage

// File: rtl/lfsr_step_en.sv
// 10-bit XNOR LFSR (taps 9,6) with step enable and synchronous load; 1-cycle update.
// Load has priority over step; an all-ones load is replaced by zero so the register never locks up.
module lfsr_step_en
  import rand_arb_pkg::*;
#(
  parameter int W = LFSR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
    end else if (load) begin
      state <= (load_val == LFSR_LOCKUP) ? '0 : load_val;
    end else if (en) begin
      state <= {state[W-2:0], ~(state[TAP_HI] ^ state[TAP_LO])};
    end
  end

endmodule

// File: rtl/rand_source_arbiter.sv
// Round-robin arbiter handing out LFSR words; grant is registered (req at edge t -> gnt after t).
// At most one grant per two cycles; requests are ignored while busy and are never queued.
module rand_source_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 10,
  parameter int WARMUP = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             rand_valid,
  output logic [WIDTH-1:0] rand_out,
  output logic             busy
);

  import rand_arb_pkg::arb_state_t;
  import rand_arb_pkg::IDLE;
  import rand_arb_pkg::GRANT;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  // With no warm-up configured the arbiter starts directly in IDLE.
  localparam arb_state_t START = (WARMUP > 0) ? rand_arb_pkg::WARMUP : IDLE;

  arb_state_t       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [PW-1:0]    rr_ptr, ptr_nx;
  logic [N_REQ-1:0] gnt_nx;
  logic             vld_nx;
  logic [WIDTH-1:0] out_nx;
  logic [WIDTH-1:0] lfsr_q;
  logic             lfsr_en;

  logic             pick_any;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  lfsr_step_en #(.W(WIDTH)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .en       (lfsr_en),
    .load     (seed_load),
    .load_val (seed),
    .state    (lfsr_q)
  );

  // Scan offsets from the far end down so the nearest requester after rr_ptr wins.
  always_comb begin
    pick_any    = 1'b0;
    pick_idx    = rr_ptr;
    pick_onehot = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[(int'(rr_ptr) + i) % N_REQ]) begin
        pick_any = 1'b1;
        pick_idx = PW'((int'(rr_ptr) + i) % N_REQ);
      end
    end
    if (pick_any) pick_onehot[pick_idx] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = rr_ptr;
    gnt_nx   = gnt;
    vld_nx   = rand_valid;
    out_nx   = rand_out;
    lfsr_en  = 1'b0;
    if (seed_load) begin
      state_nx = START;
      cnt_nx   = '0;
      gnt_nx   = '0;
      vld_nx   = 1'b0;
    end else begin
      case (state)
        rand_arb_pkg::WARMUP: begin
          lfsr_en = 1'b1;
          if (cnt == CW'(WARMUP - 1)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        IDLE: begin
          gnt_nx = '0;
          vld_nx = 1'b0;
          if (pick_any) begin
            gnt_nx   = pick_onehot;
            vld_nx   = 1'b1;
            out_nx   = lfsr_q;
            lfsr_en  = 1'b1;
            ptr_nx   = pick_idx;
            state_nx = GRANT;
          end
        end
        GRANT: begin
          gnt_nx   = '0;
          vld_nx   = 1'b0;
          state_nx = IDLE;
        end
        default: state_nx = START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= START;
      cnt        <= '0;
      rr_ptr     <= PW'(N_REQ - 1);
      gnt        <= '0;
      rand_valid <= 1'b0;
      rand_out   <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rr_ptr     <= ptr_nx;
      gnt        <= gnt_nx;
      rand_valid <= vld_nx;
      rand_out   <= out_nx;
    end
  end

  assign busy = (state == rand_arb_pkg::WARMUP);

endmodule

// File: tb/tb_rand_source_arbiter.sv
// Directed bench for rand_source_arbiter with N_REQ=4, WARMUP=4.
module tb_rand_source_arbiter;

  logic       clk;
  logic       reset;
  logic       seed_load;
  logic [9:0] seed;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       rand_valid;
  logic [9:0] rand_out;
  logic       busy;

  int passed = 0;
  int total  = 0;

  logic [3:0] g_tab [5];
  logic [9:0] r_tab [5];

  rand_source_arbiter #(.N_REQ(4), .WIDTH(10), .WARMUP(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_load  (seed_load),
    .seed       (seed),
    .req        (req),
    .gnt        (gnt),
    .rand_valid (rand_valid),
    .rand_out   (rand_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Load a seed (req already presented in the load cycle), ride out warm-up, expect one grant.
  task automatic seed_run(input string tag, input logic [9:0] s, input logic [3:0] r,
                          input logic [3:0] eg, input logic [9:0] er);
    seed      = s;
    seed_load = 1'b1;
    req       = r;
    tick();
    chk({tag, " load busy"}, busy, 1);
    chk({tag, " load gnt"}, gnt, 0);
    chk({tag, " load vld"}, rand_valid, 0);
    seed_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, " warm busy"}, busy, 1);
      chk({tag, " warm gnt"}, gnt, 0);
    end
    tick();
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle gnt"}, gnt, 0);
    tick();
    chk({tag, " gnt"}, gnt, eg);
    chk({tag, " rand"}, rand_out, er);
    chk({tag, " vld"}, rand_valid, 1);
    req = 4'b0000;
    tick();
    chk({tag, " gap gnt"}, gnt, 0);
  endtask

  initial begin
    g_tab[0] = 4'b0001; g_tab[1] = 4'b0010; g_tab[2] = 4'b0100;
    g_tab[3] = 4'b1000; g_tab[4] = 4'b0001;
    r_tab[0] = 10'h00F; r_tab[1] = 10'h01F; r_tab[2] = 10'h03F;
    r_tab[3] = 10'h07F; r_tab[4] = 10'h0FE;

    reset     = 1'b1;
    seed_load = 1'b0;
    seed      = '0;
    req       = '0;
    tick();
    tick();
    chk("rst gnt", gnt, 0);
    chk("rst vld", rand_valid, 0);
    chk("rst rand", rand_out, 0);
    chk("rst busy", busy, 1);

    // 1: warm-up after reset, no requests
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t1 busy", busy, (i < 4) ? 1 : 0);
      chk("t1 gnt", gnt, 0);
      tick();
    end

    // 2: single requester held, gap cycle between grants
    req = 4'b0001;
    tick();
    chk("t2 gnt0", gnt, 4'b0001);
    chk("t2 rand0", rand_out, 10'h00F);
    chk("t2 vld0", rand_valid, 1);
    tick();
    chk("t2 gap gnt", gnt, 0);
    chk("t2 gap vld", rand_valid, 0);
    chk("t2 gap hold", rand_out, 10'h00F);
    tick();
    chk("t2 gnt1", gnt, 4'b0001);
    chk("t2 rand1", rand_out, 10'h01F);
    req = 4'b0000;
    tick();
    chk("t2 end gnt", gnt, 0);

    // 3: all requesting after fresh reset, rotation and random sequence
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("t3 ready", busy, 0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3 gnt", gnt, g_tab[k]);
      chk("t3 rand", rand_out, r_tab[k]);
      chk("t3 vld", rand_valid, 1);
      tick();
      chk("t3 gap", gnt, 0);
    end
    req = 4'b0000;

    // 5: seed_load while a request is sampled in IDLE; rr_ptr stays at 0 so winner is 1
    seed_run("t5", 10'h155, 4'b0110, 4'b0010, 10'h150);

    // 4: seeded runs with one requester, including the lockup seed
    seed_run("t4a", 10'h155, 4'b0100, 4'b0100, 10'h150);
    seed_run("t4b", 10'h3FF, 4'b0100, 4'b0100, 10'h00F);

    // 6: reset (with seed_load) cuts a grant pulse
    req = 4'b1000;
    tick();
    chk("t6 gnt", gnt, 4'b1000);
    reset     = 1'b1;
    seed_load = 1'b1;
    seed      = 10'h155;
    req       = 4'b0001;
    tick();
    chk("t6 cut gnt", gnt, 0);
    chk("t6 cut vld", rand_valid, 0);
    chk("t6 cut rand", rand_out, 0);
    chk("t6 cut busy", busy, 1);
    reset     = 1'b0;
    seed_load = 1'b0;
    repeat (3) tick();
    chk("t6 warm busy", busy, 1);
    tick();
    chk("t6 idle busy", busy, 0);
    tick();
    chk("t6 gnt0", gnt, 4'b0001);
    chk("t6 rand0", rand_out, 10'h00F);
    req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
